// File: rtl/output_ram_stream_pkg.sv
// Shared state encoding and helpers for the output RAM stream buffer.
package output_ram_stream_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Writes are only taken in ACCEPT; every other state reports busy.
  function automatic logic is_busy(input state_t s);
    return (s != ST_ACCEPT);
  endfunction

endpackage

// File: rtl/output_ram_stream_ctrl.sv
// Sequencing for the stream buffer: FSM, clear/read pointers, count and full.
module output_ram_stream_ctrl import output_ram_stream_pkg::*; #(
  parameter  int R  = 8,
  localparam int AW = $clog2(R),
  localparam int CW = $clog2(R+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_drain,
  input  logic          i_inc,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_accept,
  output logic          o_clearing,
  output logic          o_out_valid,
  output logic          o_out_last,
  output logic [AW-1:0] o_clr_ptr,
  output logic [AW-1:0] o_rd_ptr,
  output logic [CW-1:0] o_count,
  output logic          o_full
);

  localparam logic [AW-1:0] LAST_IDX = AW'(R-1);
  localparam logic [CW-1:0] FULL_CNT = CW'(R);

  state_t r_state;
  state_t w_next;
  logic   w_xfer;
  logic   w_done;

  assign o_busy      = is_busy(r_state);
  assign o_accept    = (r_state == ST_ACCEPT);
  assign o_clearing  = (r_state == ST_CLEAR);
  assign o_out_valid = (r_state == ST_DRAIN);
  assign o_out_last  = o_out_valid && (o_rd_ptr == LAST_IDX);
  assign w_xfer      = o_out_valid && i_out_ready;
  assign w_done      = w_xfer && o_out_last;

  // State register; reset lands in CLEAR so memory is scrubbed.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_next;
  end

  // Next-state: scrub all entries, accept until drain, stream until last word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR:  if (o_clr_ptr == LAST_IDX) w_next = ST_ACCEPT;
      ST_ACCEPT: if (i_drain)               w_next = ST_DRAIN;
      ST_DRAIN:  if (w_done)                w_next = ST_CLEAR;
      default:                              w_next = ST_CLEAR;
    endcase
  end

  // Clear pointer walks 0..R-1 and parks at 0 so the next CLEAR starts clean.
  always_ff @(posedge clk) begin
    if (rst || w_done)
      o_clr_ptr <= '0;
    else if (o_clearing)
      o_clr_ptr <= (o_clr_ptr == LAST_IDX) ? '0 : o_clr_ptr + AW'(1);
  end

  // Read pointer only moves on a completed handshake, holding data during stalls.
  always_ff @(posedge clk) begin
    if (rst || o_accept || w_done)
      o_rd_ptr <= '0;
    else if (w_xfer)
      o_rd_ptr <= o_rd_ptr + AW'(1);
  end

  // Distinct-entry count with full tracked in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || w_done) begin
      o_count <= '0;
      o_full  <= 1'b0;
    end else if (i_inc) begin
      o_count <= o_count + CW'(1);
      o_full  <= ((o_count + CW'(1)) == FULL_CNT);
    end
  end

endmodule

// File: rtl/output_ram_stream.sv
// Result buffer: random-index writes, per-entry valid bits, in-order valid/ready drain.
module output_ram_stream import output_ram_stream_pkg::*; #(
  parameter  int R  = 8,
  parameter  int N  = 32,
  localparam int AW = $clog2(R),
  localparam int CW = $clog2(R+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [AW-1:0] i,
  input  logic [N-1:0]  pi,
  input  logic          drain,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last
);

  logic [N-1:0]  r_mem [R];
  logic [R-1:0]  r_valid;
  logic          w_accept;
  logic          w_clearing;
  logic          w_in_range;
  logic          w_wr_ok;
  logic          w_inc;
  logic [AW-1:0] w_clr_ptr;
  logic [AW-1:0] w_rd_ptr;

  // Index width may encode values past R-1 when R is not a power of two.
  assign w_in_range = ({1'b0, i} < (AW+1)'(R));
  assign w_wr_ok    = wr && w_in_range && w_accept && !rst;
  assign w_inc      = w_wr_ok && !r_valid[i];

  output_ram_stream_ctrl #(.R(R)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .i_drain     (drain),
    .i_inc       (w_inc),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_accept    (w_accept),
    .o_clearing  (w_clearing),
    .o_out_valid (out_valid),
    .o_out_last  (out_last),
    .o_clr_ptr   (w_clr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_count     (count),
    .o_full      (full)
  );

  // Storage: CLEAR zeroes one entry per cycle, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    if (w_clearing)   r_mem[w_clr_ptr] <= '0;
    else if (w_wr_ok) r_mem[i]         <= pi;
  end

  // Valid bits mark which entries have been written since the last clear.
  always_ff @(posedge clk) begin
    if (rst || w_clearing) r_valid    <= '0;
    else if (w_wr_ok)      r_valid[i] <= 1'b1;
  end

  assign out_data = r_mem[w_rd_ptr];
  assign out_idx  = w_rd_ptr;

endmodule
